instr_sequencer: RTL

- Multi-cycle control FSM that sequences the ALU/register-file/memory datapath, one instruction at a time.
- Latches the fetched instruction and decodes the RV32 subset add/sub/and/or/sll/lw/sw/beq.
- Drives the 4-bit ALU control code and the stage strobes (fetch, regfile read, ALU enable, memory, writeback, PC update).
- Replaces free-running phase counters with explicit, handshaked stage sequencing.

---
 rtl/instr_sequencer_pkg.sv | 33 +++
 rtl/instr_sequencer_decoder.sv | 76 +++++++
 rtl/instr_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared encodings for the multi-cycle instruction sequencer: FSM states,
// instruction classes, RV32 opcodes and ALU control codes.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    C_RTYPE  = 2'd0,
    C_LOAD   = 2'd1,
    C_STORE  = 2'd2,
    C_BRANCH = 2'd3
  } iclass_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLL = 4'b0110;

endpackage

// File: rtl/instr_sequencer_decoder.sv
// Combinational decode of the RV32 subset add/sub/and/or/sll/lw/sw/beq into
// an instruction class, ALU control code and a legal flag.
module instr_decoder
  import instr_sequencer_pkg::*;
(
  input  logic [31:0] instr_i,
  output iclass_e     iclass_o,
  output logic [3:0]  alu_control_o,
  output logic        legal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_bits;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  // Register/immediate fields are the datapath's business, not ours.
  assign unused_bits = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    iclass_o      = C_RTYPE;
    alu_control_o = ALU_ADD;
    legal_o       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        iclass_o = C_RTYPE;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) begin
              alu_control_o = ALU_ADD;
              legal_o       = 1'b1;
            end else if (funct7 == 7'b0100000) begin
              alu_control_o = ALU_SUB;
              legal_o       = 1'b1;
            end
          end
          3'b001: begin
            if (funct7 == 7'b0000000) begin
              alu_control_o = ALU_SLL;
              legal_o       = 1'b1;
            end
          end
          3'b110: begin
            alu_control_o = ALU_OR;
            legal_o       = 1'b1;
          end
          3'b111: begin
            alu_control_o = ALU_AND;
            legal_o       = 1'b1;
          end
          default: legal_o = 1'b0;
        endcase
      end
      OP_LOAD: begin
        iclass_o      = C_LOAD;
        alu_control_o = ALU_ADD;
        legal_o       = (funct3 == 3'b010);
      end
      OP_STORE: begin
        iclass_o      = C_STORE;
        alu_control_o = ALU_ADD;
        legal_o       = (funct3 == 3'b010);
      end
      OP_BRANCH: begin
        iclass_o      = C_BRANCH;
        alu_control_o = ALU_SUB;
        legal_o       = (funct3 == 3'b000);
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB], one
// instruction at a time, with a retire pulse and a retired-instruction count.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned MEM_CYCLES  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] instruction,
  input  logic        zero,
  output logic        fetch_en,
  output logic        reg_read,
  output logic        alu_en,
  output logic [3:0]  alu_control,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        instr_done,
  output logic        illegal,
  output logic        busy,
  output logic [31:0] retired
);

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);
  localparam logic [3:0] MEM_LAST  = 4'(MEM_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  alu_ctl_q, alu_ctl_d;
  logic        alu_src_q, alu_src_d;
  logic        retire;

  iclass_e     dec_class;
  logic [3:0]  dec_alu;
  logic        dec_legal;

  instr_decoder u_dec (
    .instr_i       (instr_q),
    .iclass_o      (dec_class),
    .alu_control_o (dec_alu),
    .legal_o       (dec_legal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      cnt_q     <= '0;
      alu_ctl_q <= '0;
      alu_src_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      alu_ctl_q <= alu_ctl_d;
      alu_src_q <= alu_src_d;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    cnt_d     = '0;
    alu_ctl_d = alu_ctl_q;
    alu_src_d = alu_src_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: begin
        instr_d = instruction;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_legal) begin
          alu_ctl_d = dec_alu;
          alu_src_d = (dec_class == C_LOAD) || (dec_class == C_STORE);
          state_d   = S_EXEC;
        end else begin
          alu_ctl_d = '0;
          alu_src_d = 1'b0;
          state_d   = S_ERROR;
        end
      end
      S_EXEC: begin
        if (cnt_q != EXEC_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          case (dec_class)
            C_BRANCH:        retire  = 1'b1;
            C_LOAD, C_STORE: state_d = S_MEM;
            default:         state_d = S_WB;
          endcase
        end
      end
      S_MEM: begin
        if (cnt_q != MEM_LAST) cnt_d = cnt_q + 4'd1;
        else if (dec_class == C_STORE) retire = 1'b1;
        else state_d = S_WB;
      end
      S_WB:    retire = 1'b1;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
    // run is only looked at here and in IDLE, so mid-instruction drops are harmless.
    if (retire) state_d = run ? S_FETCH : S_IDLE;
  end

  assign fetch_en    = (state_q == S_FETCH);
  assign reg_read    = (state_q == S_DECODE);
  assign alu_en      = (state_q == S_EXEC) && (cnt_q == 4'd0);
  assign alu_control = alu_ctl_q;
  assign alu_src     = alu_src_q;
  assign mem_read    = (state_q == S_MEM) && (dec_class == C_LOAD);
  assign mem_write   = (state_q == S_MEM) && (dec_class == C_STORE);
  assign mem_to_reg  = (state_q == S_WB) && (dec_class == C_LOAD);
  assign reg_write   = (state_q == S_WB);
  assign pc_write    = retire;
  assign instr_done  = retire;
  // beq retires in its final EXEC cycle, the same cycle zero is sampled, so the
  // flag is gated straight onto pc_src there.
  assign pc_src      = retire && (state_q == S_EXEC) && zero;
  assign illegal     = (state_q == S_ERROR);
  assign busy        = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign retired     = retired_q;

endmodule
